// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: instruction field positions,
// op/ext field constants and the 8-bit ALU opcodes seen by the ALU.
package cpu_pkg;

  // Instruction word layout: {op[15:12], rdest[11:8], ext[7:4], rsrc_imm[3:0]}
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 8;
  localparam int EXT_HI  = 7;
  localparam int EXT_LO  = 4;
  localparam int RS_HI   = 3;
  localparam int RS_LO   = 0;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;

  // op field values that select register form
  localparam logic [3:0] OP_REG   = 4'h0;
  localparam logic [3:0] OP_SHIFT = 4'h8;

  // ext field values used with OP_SHIFT / OP_REG
  localparam logic [3:0] EXT_LSH    = 4'h4;
  localparam logic [3:0] EXT_ASHU   = 4'h6;
  localparam logic [3:0] EXT_WEIGHT = 4'h0;

  // 8-bit ALU opcodes
  localparam logic [7:0] ALU_ADD    = 8'h05;
  localparam logic [7:0] ALU_ADDU   = 8'h06;
  localparam logic [7:0] ALU_ADDC   = 8'h07;
  localparam logic [7:0] ALU_MULT   = 8'h0E;
  localparam logic [7:0] ALU_SUB    = 8'h09;
  localparam logic [7:0] ALU_SUBC   = 8'h0A;
  localparam logic [7:0] ALU_CMP    = 8'h0B;
  localparam logic [7:0] ALU_AND    = 8'h01;
  localparam logic [7:0] ALU_OR     = 8'h02;
  localparam logic [7:0] ALU_XOR    = 8'h03;
  localparam logic [7:0] ALU_LSH    = 8'h84;
  localparam logic [7:0] ALU_ASHU   = 8'h86;
  localparam logic [7:0] ALU_WEIGHT = 8'h00;

  // The ten arithmetic/logic codes: valid as an immediate op, or as ext under OP_REG
  function automatic logic is_alu_nibble(input logic [3:0] n);
    case (n)
      4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Logic operations take a zero-extended immediate; arithmetic ones sign-extend
  function automatic logic is_logic_op(input logic [3:0] n);
    return (n == 4'h1) || (n == 4'h2) || (n == 4'h3);
  endfunction

endpackage

// File: rtl/decode_regread_if.sv
// Bus bundle for decode_regread: instruction input, decoded output slot and
// register writeback port.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until the
// transfer; ready may depend combinationally on the consumer side
// (in_ready = !out_valid | out_ready).
interface decode_regread_if;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] r1;
  logic [15:0] r2;
  logic [7:0]  opcode;
  logic [3:0]  rdest;
  logic        wb_req;
  logic        illegal;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;

  modport master (
    output in_valid, in_instr, out_ready, wb_we, wb_addr, wb_data,
    input  in_ready, out_valid, r1, r2, opcode, rdest, wb_req, illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready, wb_we, wb_addr, wb_data,
    output in_ready, out_valid, r1, r2, opcode, rdest, wb_req, illegal
  );
endinterface

// File: rtl/regfile16.sv
// 16x16 register file: two asynchronous read ports, one synchronous write
// port, asynchronous reset to zero. R0 is an ordinary writable register.
module regfile16 #(
  parameter int NREGS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [3:0]  raddr_a,
  output logic [15:0] rdata_a,
  input  logic [3:0]  raddr_b,
  output logic [15:0] rdata_b
);

  logic [15:0] mem [NREGS];

  // Synchronous write; reset clears every register and wins over a write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports see the pre-write contents during a same-cycle write
  always_comb begin
    rdata_a = mem[raddr_a];
    rdata_b = mem[raddr_b];
  end

endmodule

// File: rtl/decode_regread.sv
// Decode and register-read stage in front of the ALU. Decodes one instruction
// per cycle into ALU opcode / destination, reads both operands and holds the
// result in a single registered output slot.
// Optional feature macro: DECODE_FORWARD_EN (writeback-to-operand forwarding,
// both at capture and while the slot is held).
module decode_regread
  import cpu_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic clk,
  input  logic reset,
  decode_regread_if.slave bus
);

  logic [3:0]  f_op, f_rd, f_ext, f_rs;
  logic [7:0]  f_imm;
  logic [7:0]  dec_opcode;
  logic        dec_illegal, dec_imm_form, dec_wb_req;
  logic [15:0] dec_imm;
  logic [15:0] rf_a, rf_b;
  logic [15:0] cap_r1, cap_r2;
  logic        accept;

  logic        valid_q;
  logic [15:0] r1_q, r2_q;
  logic [7:0]  opcode_q;
  logic [3:0]  rdest_q;
  logic        wb_req_q, illegal_q;
`ifdef DECODE_FORWARD_EN
  logic [3:0]  rs_q;
  logic        reg_form_q;
`endif

  assign f_op  = bus.in_instr[OP_HI:OP_LO];
  assign f_rd  = bus.in_instr[RD_HI:RD_LO];
  assign f_ext = bus.in_instr[EXT_HI:EXT_LO];
  assign f_rs  = bus.in_instr[RS_HI:RS_LO];
  assign f_imm = bus.in_instr[IMM_HI:IMM_LO];

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  regfile16 #(.NREGS(NREGS)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (bus.wb_we),
    .waddr   (bus.wb_addr),
    .wdata   (bus.wb_data),
    .raddr_a (f_rd),
    .rdata_a (rf_a),
    .raddr_b (f_rs),
    .rdata_b (rf_b)
  );

  // Instruction decode: register form, immediate form or illegal
  always_comb begin
    dec_opcode   = '0;
    dec_illegal  = 1'b0;
    dec_imm_form = 1'b0;
    dec_imm      = '0;
    if (f_op == OP_REG && (is_alu_nibble(f_ext) || f_ext == EXT_WEIGHT)) begin
      dec_opcode = {f_op, f_ext};
    end else if (f_op == OP_SHIFT && (f_ext == EXT_LSH || f_ext == EXT_ASHU)) begin
      dec_opcode = {f_op, f_ext};
    end else if (is_alu_nibble(f_op)) begin
      dec_imm_form = 1'b1;
      dec_opcode   = {4'h0, f_op};
      dec_imm      = is_logic_op(f_op) ? {8'h00, f_imm} : {{8{f_imm[7]}}, f_imm};
    end else begin
      dec_illegal = 1'b1;
    end
    dec_wb_req = !dec_illegal && (dec_opcode != ALU_CMP) && (dec_opcode != ALU_WEIGHT);
  end

  // Operand selection, with same-cycle writeback bypass when forwarding is on
  always_comb begin
    cap_r1 = rf_a;
    cap_r2 = dec_imm_form ? dec_imm : rf_b;
`ifdef DECODE_FORWARD_EN
    if (bus.wb_we && bus.wb_addr == f_rd) cap_r1 = bus.wb_data;
    if (bus.wb_we && !dec_imm_form && bus.wb_addr == f_rs) cap_r2 = bus.wb_data;
`endif
  end

  // Output slot: load on accept, drop on drain, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      r1_q       <= '0;
      r2_q       <= '0;
      opcode_q   <= '0;
      rdest_q    <= '0;
      wb_req_q   <= 1'b0;
      illegal_q  <= 1'b0;
`ifdef DECODE_FORWARD_EN
      rs_q       <= '0;
      reg_form_q <= 1'b0;
`endif
    end else if (accept) begin
      valid_q    <= 1'b1;
      r1_q       <= cap_r1;
      r2_q       <= cap_r2;
      opcode_q   <= dec_opcode;
      rdest_q    <= f_rd;
      wb_req_q   <= dec_wb_req;
      illegal_q  <= dec_illegal;
`ifdef DECODE_FORWARD_EN
      rs_q       <= f_rs;
      reg_form_q <= !dec_imm_form;
`endif
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
`ifdef DECODE_FORWARD_EN
    else if (valid_q && bus.wb_we) begin
      // Held slot tracks writebacks to its source registers; immediates stay put
      if (bus.wb_addr == rdest_q) r1_q <= bus.wb_data;
      if (reg_form_q && bus.wb_addr == rs_q) r2_q <= bus.wb_data;
    end
`endif
  end

  assign bus.out_valid = valid_q;
  assign bus.r1        = r1_q;
  assign bus.r2        = r2_q;
  assign bus.opcode    = opcode_q;
  assign bus.rdest     = rdest_q;
  assign bus.wb_req    = wb_req_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_decode_regread.sv
// Self-checking bench for decode_regread: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the stage.
module tb_decode_regread;

  logic clk;
  logic reset;
  decode_regread_if bus ();

  decode_regread #(.NREGS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model state
  logic [15:0] rf_m [16];
  // Entry: {reg_form, rs[3:0], illegal, wb_req, rdest[3:0], opcode[7:0], r2[15:0], r1[15:0]}
  localparam int W = 51;
  logic [W-1:0] exp_q [$];

  localparam logic [7:0] REG_OPS [13] = '{8'h05, 8'h06, 8'h07, 8'h0E, 8'h09, 8'h0A,
                                          8'h0B, 8'h01, 8'h02, 8'h03, 8'h84, 8'h86, 8'h00};
  localparam logic [3:0] IMM_OPS [10] = '{4'h5, 4'h6, 4'h7, 4'hE, 4'h9, 4'hA,
                                          4'hB, 4'h1, 4'h2, 4'h3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Architectural decode of one instruction using the current model RF
  function automatic logic [W-1:0] model_decode(input logic [15:0] instr,
                                                input logic we, input logic [3:0] wa,
                                                input logic [15:0] wd);
    logic [3:0]  op, rd, ext, rs;
    logic [7:0]  full, imm8, opc;
    logic        is_reg, is_imm, ill, wbr;
    logic [15:0] a, b;
    int          v;
    op = instr[15:12]; rd = instr[11:8]; ext = instr[7:4]; rs = instr[3:0];
    imm8 = instr[7:0];
    full = {op, ext};
    is_reg = 1'b0; is_imm = 1'b0;
    foreach (REG_OPS[i]) if (full == REG_OPS[i]) is_reg = 1'b1;
    foreach (IMM_OPS[i]) if (op == IMM_OPS[i]) is_imm = 1'b1;
    ill = !is_reg && !is_imm;
    a = rf_m[rd];
    b = rf_m[rs];
`ifdef DECODE_FORWARD_EN
    if (we && wa == rd) a = wd;
    if (we && wa == rs) b = wd;
`else
    if (we && wa == 4'hF && wd == 16'h0) a = a;  // no bypass in this build
`endif
    if (is_reg) begin
      opc = full;
    end else if (is_imm) begin
      opc = {4'h0, op};
      if (op >= 4'h1 && op <= 4'h3) v = int'(imm8);
      else v = (imm8 >= 8'd128) ? int'(imm8) - 256 : int'(imm8);
      b = v[15:0];
    end else begin
      opc = 8'h00;
    end
    wbr = !ill && opc != 8'h0B && opc != 8'h00;
    return {!is_imm, rs, ill, wbr, rd, opc, b, a};
  endfunction

  // One clock cycle: drive inputs, check in_ready, advance model, check outputs
  task automatic step(input logic iv, input logic [15:0] instr, input logic ordy,
                      input logic we, input logic [3:0] wa, input logic [15:0] wd);
    logic exp_rdy;
    logic [W-1:0] e;
    bus.in_valid  = iv;
    bus.in_instr  = instr;
    bus.out_ready = ordy;
    bus.wb_we     = we;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
    #1;
    exp_rdy = (exp_q.size() == 0) || ordy;
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    if (exp_q.size() != 0 && ordy) begin
      void'(exp_q.pop_front());
    end else if (exp_q.size() != 0) begin
`ifdef DECODE_FORWARD_EN
      if (we) begin
        e = exp_q[0];
        if (wa == e[43:40]) e[15:0] = wd;
        if (e[50] && wa == e[49:46]) e[31:16] = wd;
        exp_q[0] = e;
      end
`endif
    end
    if (iv && exp_rdy) exp_q.push_back(model_decode(instr, we, wa, wd));
    if (we) rf_m[wa] = wd;
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check("r1",      {16'd0, bus.r1},     {16'd0, e[15:0]});
      if (!e[45]) check("r2", {16'd0, bus.r2}, {16'd0, e[31:16]});
      check("opcode",  {24'd0, bus.opcode}, {24'd0, e[39:32]});
      check("rdest",   {28'd0, bus.rdest},  {28'd0, e[43:40]});
      check("wb_req",  {31'd0, bus.wb_req}, {31'd0, e[44]});
      check("illegal", {31'd0, bus.illegal},{31'd0, e[45]});
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    step(1'b0, 16'h0000, 1'b1, 1'b1, a, d);
  endtask

  task automatic model_reset();
    foreach (rf_m[i]) rf_m[i] = 16'h0000;
    exp_q.delete();
  endtask

  logic [15:0] held_r1, held_r2;
  logic [15:0] rnd_instr;

  initial begin
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b0;
    bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_r1",        {16'd0, bus.r1},        32'd0);
    check("rst_r2",        {16'd0, bus.r2},        32'd0);
    check("rst_opcode",    {24'd0, bus.opcode},    32'd0);
    check("rst_rdest",     {28'd0, bus.rdest},     32'd0);
    check("rst_wb_req",    {31'd0, bus.wb_req},    32'd0);
    check("rst_illegal",   {31'd0, bus.illegal},   32'd0);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    reset = 1'b0;

    // Immediate ADD with sign extension
    wr(4'd3, 16'h0010);
    step(1'b1, 16'h53F0, 1'b1, 1'b0, 4'd0, 16'h0);
    check("addi_opcode", {24'd0, bus.opcode}, 32'h05);
    check("addi_r1",     {16'd0, bus.r1},     32'h0010);
    check("addi_r2",     {16'd0, bus.r2},     32'hFFF0);
    check("addi_rdest",  {28'd0, bus.rdest},  32'd3);
    check("addi_wb_req", {31'd0, bus.wb_req}, 32'd1);

    // Immediate AND with zero extension
    step(1'b1, 16'h1380, 1'b1, 1'b0, 4'd0, 16'h0);
    check("andi_r2",     {16'd0, bus.r2},     32'h0080);
    check("andi_opcode", {24'd0, bus.opcode}, 32'h01);

    // Register CMP
    wr(4'd1, 16'h1234);
    wr(4'd2, 16'h00FF);
    step(1'b1, 16'h02B1, 1'b1, 1'b0, 4'd0, 16'h0);
    check("cmp_opcode", {24'd0, bus.opcode}, 32'h0B);
    check("cmp_r1",     {16'd0, bus.r1},     32'h00FF);
    check("cmp_r2",     {16'd0, bus.r2},     32'h1234);
    check("cmp_wb_req", {31'd0, bus.wb_req}, 32'd0);

    // Illegal encoding
    step(1'b1, 16'h4000, 1'b1, 1'b0, 4'd0, 16'h0);
    check("ill_illegal", {31'd0, bus.illegal}, 32'd1);
    check("ill_opcode",  {24'd0, bus.opcode},  32'h00);
    check("ill_wb_req",  {31'd0, bus.wb_req},  32'd0);

    // Backpressure: slot full, ALU stalls three cycles
    step(1'b1, 16'h0612, 1'b0, 1'b0, 4'd0, 16'h0);
    held_r1 = bus.r1; held_r2 = bus.r2;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h9701, 1'b0, 1'b0, 4'd0, 16'h0);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_r1_hold",  {16'd0, bus.r1}, {16'd0, held_r1});
      check("bp_r2_hold",  {16'd0, bus.r2}, {16'd0, held_r2});
    end
    step(1'b1, 16'h9701, 1'b1, 1'b0, 4'd0, 16'h0);
    check("bp_release_opcode", {24'd0, bus.opcode}, 32'h09);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 16'h0);
    check("bp_drained", {31'd0, bus.out_valid}, 32'd0);

    // Writeback on the accept cycle
    wr(4'd1, 16'h1111);
    step(1'b1, 16'h0251, 1'b1, 1'b1, 4'd1, 16'hBEEF);
`ifdef DECODE_FORWARD_EN
    check("fwd_r2", {16'd0, bus.r2}, 32'hBEEF);
`else
    check("fwd_r2", {16'd0, bus.r2}, 32'h1111);
`endif
    step(1'b1, 16'h0110, 1'b1, 1'b0, 4'd0, 16'h0);
    check("fwd_r1_after", {16'd0, bus.r1}, 32'hBEEF);

    // Write-after-write to the same register keeps the last value
    wr(4'd7, 16'hAAAA);
    wr(4'd7, 16'h5555);
    step(1'b1, 16'h0750, 1'b1, 1'b0, 4'd0, 16'h0);
    check("waw_r1", {16'd0, bus.r1}, 32'h5555);

    // Asynchronous reset mid-operation, with a write pending
    wr(4'd5, 16'h7777);
    step(1'b1, 16'h0350, 1'b0, 1'b0, 4'd0, 16'h0);
    bus.wb_we = 1'b1; bus.wb_addr = 4'd5; bus.wb_data = 16'h9999;
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    step(1'b1, 16'h0550, 1'b1, 1'b0, 4'd0, 16'h0);
    check("arst_r5_cleared", {16'd0, bus.r1}, 32'h0000);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rnd_instr = 16'($urandom);
      else rnd_instr = {IMM_OPS[$urandom_range(0, 9)], 4'($urandom), 8'($urandom)};
      if ($urandom_range(0, 3) == 0) rnd_instr[15:12] = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'h8;
      step(1'($urandom_range(0, 3) != 0), rnd_instr, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom));
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 16'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
